conv_window_sequencer: RTL

//  Control FSM that drives the 3x3-conv / 2x2-maxpool MAC datapath. Walks frames in input SRAM, reads the
//  3x3 kernel once per run from weights SRAM, streams each 4x4 input window (8 words) into the datapath

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_addr_gen.sv | 70 +++++++
 rtl/conv_window_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv window sequencer and its address generator.
package conv_pkg;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 16;
    localparam int N_MAX      = 64;
    localparam int KERN_WORDS = 5;

    localparam logic [DATA_W-1:0] FRAME_TERM = 16'h00FF;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = 'd1;

    typedef enum logic [2:0] {IDLE, KERN, HDR, WIN, MAC} state_t;

    typedef logic [2:0] slot_t;
    typedef logic [6:0] dim_t;

    // A usable frame is even-sized and between 4 and N_MAX pixels on a side
    function automatic logic dim_legal(input dim_t n);
        return !n[0] && (n >= dim_t'(4)) && (n <= dim_t'(N_MAX));
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Frame pointer, row/window base addresses and output-position counters for the window walk.
module conv_addr_gen
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              clear,
    input  logic              load,
    input  logic              advance,
    input  dim_t              n_in,
    output logic [ADDR_W-1:0] frame_ptr,
    output logic [ADDR_W-1:0] first_base,
    output logic [ADDR_W-1:0] half,
    output logic [ADDR_W-1:0] next_win_base,
    output logic [ADDR_W-1:0] next_frame_ptr,
    output logic              col_last,
    output logic              row_last
);

    logic [ADDR_W-1:0] frame_ptr_reg;
    logic [ADDR_W-1:0] row_base_reg;
    logic [ADDR_W-1:0] win_base_reg;
    logic [ADDR_W-1:0] n_ext;
    dim_t              n_reg;
    dim_t              r_reg;
    dim_t              c_reg;

    assign n_ext      = ADDR_W'(n_reg);
    assign half       = n_ext >> 1;
    assign frame_ptr  = frame_ptr_reg;
    assign first_base = frame_ptr_reg + ADDR_ONE;
    assign col_last   = (c_reg == n_reg - dim_t'(4));
    assign row_last   = (r_reg == n_reg - dim_t'(4));

    // Two rows of N/2 words per vertical step; the last window row sits 2N words before the next header
    assign next_win_base  = col_last ? (row_base_reg + n_ext) : (win_base_reg + ADDR_ONE);
    assign next_frame_ptr = row_base_reg + (n_ext << 1);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            frame_ptr_reg <= '0;
            row_base_reg  <= '0;
            win_base_reg  <= '0;
            n_reg         <= '0;
            r_reg         <= '0;
            c_reg         <= '0;
        end else if (clear) begin
            frame_ptr_reg <= '0;
        end else if (load) begin
            n_reg        <= n_in;
            r_reg        <= '0;
            c_reg        <= '0;
            row_base_reg <= first_base;
            win_base_reg <= first_base;
        end else if (advance) begin
            win_base_reg <= next_win_base;
            if (col_last) begin
                c_reg        <= '0;
                r_reg        <= r_reg + dim_t'(2);
                row_base_reg <= row_base_reg + n_ext;
                if (row_last) begin
                    frame_ptr_reg <= next_frame_ptr;
                end
            end else begin
                c_reg <= c_reg + dim_t'(2);
            end
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Run-control FSM feeding kernel and 4x4 windows into the MAC/pool datapath.
// Optional ROW_REUSE_EN: reuse the left column word pair when stepping right along a row.
module conv_window_sequencer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] input_sram_read_address,
    input  logic [DATA_W-1:0] input_sram_read_data,
    output logic [ADDR_W-1:0] weights_sram_read_address,
    input  logic [DATA_W-1:0] weights_sram_read_data,
    output logic              kern_wr_en,
    output logic [2:0]        kern_wr_slot,
    output logic              win_wr_en,
    output logic [2:0]        win_wr_slot,
    output logic [DATA_W-1:0] win_wr_data,
    output logic              win_shift,
    output logic              mac_start,
    input  logic              mac_done,
    output logic              frame_start
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] in_addr_reg, in_addr_next;
    logic [ADDR_W-1:0] wt_addr_reg, wt_addr_next;
    slot_t             cnt_reg, cnt_next;
    logic              kern_en_reg, kern_en_next;
    slot_t             kern_slot_reg, kern_slot_next;
    logic              win_en_reg, win_en_next;
    slot_t             win_slot_reg, win_slot_next;
    logic              shift_reg, shift_next;
    logic              mac_start_reg, mac_start_next;
    logic              mac_issued_reg, mac_issued_next;
    logic              frame_start_reg, frame_start_next;
    logic              reuse_reg, reuse_next;

    logic              ag_clear, ag_load, ag_advance;
    logic [ADDR_W-1:0] frame_ptr, first_base, half, next_win_base, next_frame_ptr;
    logic              col_last, row_last;
    logic              hdr_term;
    logic              reuse_avail;

    conv_addr_gen u_addr_gen (
        .clk            (clk),
        .reset_b        (reset_b),
        .clear          (ag_clear),
        .load           (ag_load),
        .advance        (ag_advance),
        .n_in           (input_sram_read_data[6:0]),
        .frame_ptr      (frame_ptr),
        .first_base     (first_base),
        .half           (half),
        .next_win_base  (next_win_base),
        .next_frame_ptr (next_frame_ptr),
        .col_last       (col_last),
        .row_last       (row_last)
    );

`ifdef ROW_REUSE_EN
    assign reuse_avail = !col_last;
`else
    assign reuse_avail = 1'b0;
`endif

    assign hdr_term = (input_sram_read_data == FRAME_TERM) || !dim_legal(input_sram_read_data[6:0]);

    always_comb begin
        state_next       = state_reg;
        in_addr_next     = in_addr_reg;
        wt_addr_next     = wt_addr_reg;
        cnt_next         = cnt_reg;
        kern_en_next     = 1'b0;
        kern_slot_next   = kern_slot_reg;
        win_en_next      = 1'b0;
        win_slot_next    = win_slot_reg;
        shift_next       = 1'b0;
        mac_start_next   = 1'b0;
        mac_issued_next  = mac_issued_reg;
        frame_start_next = 1'b0;
        reuse_next       = reuse_reg;
        ag_clear         = 1'b0;
        ag_load          = 1'b0;
        ag_advance       = 1'b0;
        if (dut_run) begin
            state_next      = KERN;
            wt_addr_next    = '0;
            cnt_next        = '0;
            mac_issued_next = 1'b0;
            reuse_next      = 1'b0;
            ag_clear        = 1'b1;
        end else begin
            case (state_reg)
                KERN: begin
                    kern_en_next   = 1'b1;
                    kern_slot_next = cnt_reg;
                    if (cnt_reg == slot_t'(KERN_WORDS - 1)) begin
                        state_next   = HDR;
                        in_addr_next = frame_ptr;
                        cnt_next     = '0;
                    end else begin
                        cnt_next     = cnt_reg + slot_t'(1);
                        wt_addr_next = wt_addr_reg + ADDR_ONE;
                    end
                end
                HDR: begin
                    // First cycle only presents the address; the header word is valid on the second
                    if (cnt_reg == '0) begin
                        cnt_next = slot_t'(1);
                    end else if (hdr_term) begin
                        state_next = IDLE;
                    end else begin
                        state_next       = WIN;
                        ag_load          = 1'b1;
                        frame_start_next = 1'b1;
                        in_addr_next     = first_base;
                        cnt_next         = '0;
                        reuse_next       = 1'b0;
                    end
                end
                WIN: begin
                    win_en_next   = 1'b1;
                    win_slot_next = cnt_reg;
                    if (cnt_reg == slot_t'(7)) begin
                        state_next      = MAC;
                        mac_issued_next = 1'b0;
                    end else if (reuse_reg) begin
                        cnt_next     = cnt_reg + slot_t'(2);
                        in_addr_next = in_addr_reg + half;
                    end else if (!cnt_reg[0]) begin
                        cnt_next     = cnt_reg + slot_t'(1);
                        in_addr_next = in_addr_reg + ADDR_ONE;
                    end else begin
                        cnt_next     = cnt_reg + slot_t'(1);
                        in_addr_next = in_addr_reg + half - ADDR_ONE;
                    end
                end
                MAC: begin
                    // mac_done only counts once this window's mac_start has gone out
                    if (win_en_reg && !mac_issued_reg) begin
                        mac_start_next  = 1'b1;
                        mac_issued_next = 1'b1;
                    end else if (mac_issued_reg && mac_done) begin
                        ag_advance = 1'b1;
                        if (col_last && row_last) begin
                            state_next   = HDR;
                            in_addr_next = next_frame_ptr;
                            cnt_next     = '0;
                        end else begin
                            state_next   = WIN;
                            reuse_next   = reuse_avail;
                            shift_next   = reuse_avail;
                            cnt_next     = reuse_avail ? slot_t'(1) : slot_t'(0);
                            in_addr_next = next_win_base + (reuse_avail ? ADDR_ONE : '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_reg       <= IDLE;
            in_addr_reg     <= '0;
            wt_addr_reg     <= '0;
            cnt_reg         <= '0;
            kern_en_reg     <= 1'b0;
            kern_slot_reg   <= '0;
            win_en_reg      <= 1'b0;
            win_slot_reg    <= '0;
            shift_reg       <= 1'b0;
            mac_start_reg   <= 1'b0;
            mac_issued_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            reuse_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            in_addr_reg     <= in_addr_next;
            wt_addr_reg     <= wt_addr_next;
            cnt_reg         <= cnt_next;
            kern_en_reg     <= kern_en_next;
            kern_slot_reg   <= kern_slot_next;
            win_en_reg      <= win_en_next;
            win_slot_reg    <= win_slot_next;
            shift_reg       <= shift_next;
            mac_start_reg   <= mac_start_next;
            mac_issued_reg  <= mac_issued_next;
            frame_start_reg <= frame_start_next;
            reuse_reg       <= reuse_next;
        end
    end

    assign dut_busy                  = (state_reg != IDLE);
    assign input_sram_read_address   = in_addr_reg;
    assign weights_sram_read_address = wt_addr_reg;
    assign kern_wr_en                = kern_en_reg;
    assign kern_wr_slot              = kern_slot_reg;
    assign win_wr_en                 = win_en_reg;
    assign win_wr_slot               = win_slot_reg;
    assign win_shift                 = shift_reg;
    assign mac_start                 = mac_start_reg;
    assign frame_start               = frame_start_reg;
    assign win_wr_data = kern_en_reg ? weights_sram_read_data :
                         win_en_reg  ? input_sram_read_data   : '0;

endmodule
